// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-side/decode-side bundle of the instruction fetch queue
interface inst_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              flush_i;
  logic              icache_resp_valid_i;
  logic [ADDR_W-1:0] icache_resp_pc_i;
  logic [INST_W-1:0] icache_resp_inst_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              stall_req_o;
  logic              overflow_o;
  logic [CW-1:0]     count_o;
  modport master (
    output flush_i, icache_resp_valid_i, icache_resp_pc_i, icache_resp_inst_i, id_ready_i,
    input  id_valid_o, id_pc_o, id_inst_o, stall_req_o, overflow_o, count_o
  );
  modport slave (
    input  flush_i, icache_resp_valid_i, icache_resp_pc_i, icache_resp_inst_i, id_ready_i,
    output id_valid_o, id_pc_o, id_inst_o, stall_req_o, overflow_o, count_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: show-ahead FIFO of icache responses toward decode, with stall,
// sticky overflow and wrong-path drop after a branch redirect
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input logic clk,
  input logic rst,
  inst_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {NORMAL, DROP} state_t;
  state_t r_state, w_state_nxt;
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_count, w_next_count;
  logic [ADDR_W+INST_W-1:0] r_mem [DEPTH];
  logic r_stall, r_overflow;
  logic w_empty, w_full, w_pop, w_cand, w_push, w_ovf;
  always_comb begin
    w_count      = r_wr_ptr - r_rd_ptr;
    w_empty      = r_wr_ptr == r_rd_ptr;
    w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop        = !w_empty && bus.id_ready_i && !bus.flush_i;
    w_cand       = bus.icache_resp_valid_i && r_state == NORMAL && !bus.flush_i;
    w_push       = w_cand && (!w_full || w_pop);
    w_ovf        = w_cand && w_full && !w_pop;
    w_next_count = bus.flush_i ? '0 : w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    // the one response already in flight after a redirect is wrong-path
    w_state_nxt  = bus.flush_i ? DROP :
                   (r_state == DROP && bus.icache_resp_valid_i) ? NORMAL : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= NORMAL;
    else     r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= bus.flush_i ? '0 : r_wr_ptr + (AW+1)'(w_push);
      r_rd_ptr   <= bus.flush_i ? '0 : r_rd_ptr + (AW+1)'(w_pop);
      // threshold at DEPTH-1 keeps a slot free for the response in flight
      r_stall    <= (w_next_count >= (AW+1)'(DEPTH-1)) && !bus.flush_i;
      r_overflow <= r_overflow || w_ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.icache_resp_pc_i, bus.icache_resp_inst_i};
  end
  always_comb begin
    bus.id_valid_o               = !w_empty;
    {bus.id_pc_o, bus.id_inst_o} = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    bus.stall_req_o              = r_stall;
    bus.overflow_o               = r_overflow;
    bus.count_o                  = w_count;
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus with a scoreboard queue checked by a decode-side monitor
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [95:0] exp_q[$];
  inst_fetch_queue_if #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) bus ();
  inst_fetch_queue #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.id_valid_o && bus.id_ready_i && !bus.flush_i) begin
      if (exp_q.size() == 0) chk("unexpected_pop", bus.id_pc_o, 64'hffff_ffff_ffff_ffff);
      else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", bus.id_pc_o, e[95:32]);
        chk("pop_inst", {32'h0, bus.id_inst_o}, {32'h0, e[31:0]});
      end
    end
  end
  task automatic step(logic v, logic [63:0] pc, logic fl, logic acc);
    bus.icache_resp_valid_i = v;
    bus.icache_resp_pc_i    = pc;
    bus.icache_resp_inst_i  = inst_of(pc);
    bus.flush_i             = fl;
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back({pc, inst_of(pc)});
    @(posedge clk);
    #1;
    bus.icache_resp_valid_i = 1'b0;
    bus.flush_i             = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.flush_i = 1'b0;
    bus.icache_resp_valid_i = 1'b0;
    bus.icache_resp_pc_i = '0;
    bus.icache_resp_inst_i = '0;
    bus.id_ready_i = 1'b1;
    #12;
    chk("rst_count", 64'(bus.count_o), 0);
    chk("rst_valid", 64'(bus.id_valid_o), 0);
    chk("rst_pc", bus.id_pc_o, 0);
    chk("rst_stall", 64'(bus.stall_req_o), 0);
    chk("rst_ovf", 64'(bus.overflow_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      step(1, 64'h8000_0000 + 64'(4*i), 0, 1);
      chk("stream_valid", 64'(bus.id_valid_o), 1);
      chk("stream_count", 64'(bus.count_o), 1);
    end
    step(0, 0, 0, 0);
    chk("stream_drained", 64'(bus.id_valid_o), 0);
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 64'h8000_0100 + 64'(4*i), 0, 1);
      chk("fill_count", 64'(bus.count_o), 64'(i+1));
      chk("fill_stall", 64'(bus.stall_req_o), i == 2 ? 1 : 0);
    end
    step(1, 64'h8000_010c, 0, 1);
    chk("full_count", 64'(bus.count_o), 4);
    chk("full_noovf", 64'(bus.overflow_o), 0);
    step(1, 64'h8000_0110, 0, 0);
    chk("ovf_set", 64'(bus.overflow_o), 1);
    chk("ovf_count", 64'(bus.count_o), 4);
    step(0, 0, 0, 0);
    chk("ovf_sticky", 64'(bus.overflow_o), 1);
    bus.id_ready_i = 1'b1;
    step(1, 64'h8000_0200, 0, 1);
    chk("fullpp_count", 64'(bus.count_o), 4);
    chk("fullpp_stall", 64'(bus.stall_req_o), 1);
    step(0, 0, 0, 0);
    chk("drain3_stall", 64'(bus.stall_req_o), 1);
    step(0, 0, 0, 0);
    chk("drain2_stall", 64'(bus.stall_req_o), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("drain_count", 64'(bus.count_o), 0);
    bus.id_ready_i = 1'b0;
    step(1, 64'h8000_0300, 0, 1);
    step(1, 64'h8000_0304, 0, 1);
    chk("preflush_count", 64'(bus.count_o), 2);
    step(1, 64'h8000_0308, 1, 0);
    chk("flush_count", 64'(bus.count_o), 0);
    chk("flush_valid", 64'(bus.id_valid_o), 0);
    chk("flush_pc", bus.id_pc_o, 0);
    step(1, 64'h8000_000c, 0, 0);
    chk("stale_dropped", 64'(bus.count_o), 0);
    step(1, 64'h8000_1000, 0, 1);
    chk("redirect_count", 64'(bus.count_o), 1);
    chk("redirect_pc", bus.id_pc_o, 64'h8000_1000);
    bus.id_ready_i = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 64'h8000_2000, 1, 0);
    chk("b2b_count", 64'(bus.count_o), 0);
    step(1, 64'h8000_2004, 0, 0);
    chk("b2b_stale", 64'(bus.count_o), 0);
    step(1, 64'h8000_3000, 0, 1);
    chk("b2b_accept", 64'(bus.count_o), 1);
    step(0, 0, 0, 0);
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 64'h8000_4000 + 64'(4*i), 0, 1);
    chk("prerst_stall", 64'(bus.stall_req_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.id_valid_o), 0);
    chk("arst_count", 64'(bus.count_o), 0);
    chk("arst_pc", bus.id_pc_o, 0);
    chk("arst_inst", 64'(bus.id_inst_o), 0);
    chk("arst_stall", 64'(bus.stall_req_o), 0);
    chk("arst_ovf", 64'(bus.overflow_o), 0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, 64'h8000_5000, 0, 1);
    chk("postrst_count", 64'(bus.count_o), 1);
    bus.id_ready_i = 1'b1;
    step(0, 0, 0, 0);
    chk("postrst_empty", 64'(bus.count_o), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch queue directly downstream of the PC/icache-request stage. Captures icache responses (pc, instruction pairs) into a small FIFO and presents them in order to the decode stage over a valid/ready handshake.
- Back-pressures the PC stage through a stall request.
- Discards wrong-path responses after a branch redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- ADDR_W, 64, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  branch redirect; same cycle the PC stage loads its new PC.
- icache_resp_valid_i  input  1  icache response valid this cycle.
- icache_resp_pc_i  input  ADDR_W  PC of the returned instruction.
- icache_resp_inst_i  input  INST_W  returned instruction word.
- id_valid_o  output  1  head entry valid toward decode.
- id_ready_i  input  1  decode accepts head entry this cycle.
- id_pc_o  output  ADDR_W  head entry PC.
- id_inst_o  output  INST_W  head entry instruction.
- stall_req_o  output  1  request the PC stage to hold (drives its stalled control state).
- overflow_o  output  1  sticky error: a response was lost because the queue was full.
- count_o  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - rd/wr pointers = 0, count_o = 0.
  - FSM = NORMAL.
  - overflow_o = 0, stall_req_o = 0, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all entries.
- Pointers: log2(DEPTH)+1 bits; wrap naturally. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ. count_o = wr_ptr - rd_ptr.
- Output is show-ahead:
  - id_valid_o = !empty.
  - id_pc_o and id_inst_o come combinationally from the head entry.
  - Both are forced to 0 when empty.
- pop = id_valid_o & id_ready_i & !flush_i. It advances rd_ptr on the next edge.
- FSM states:
  - NORMAL: responses are candidates for push.
  - DROP: the next response is wrong-path.
    - DROP + icache_resp_valid_i -> discard the response, go to NORMAL.
    - DROP without a response -> stay in DROP.
  - Any state + flush_i -> DROP. flush_i has priority over leaving DROP.
  - The icache has fixed 1-cycle latency, so exactly one stale response can follow a redirect.
- push = icache_resp_valid_i & state==NORMAL & !flush_i & (!full | pop).
  - Writes {pc, inst} at wr_ptr and advances wr_ptr.
  - Push and pop together when full is legal; count stays at DEPTH.
- Flush:
  - On the next edge both pointers are set to 0 and count becomes 0.
  - A response in the flush cycle is discarded.
  - A pop in the flush cycle does not occur.
  - id_valid_o stays combinational, so it may be 1 during the flush cycle. Decode must qualify it with flush_i.
- Overflow: icache_resp_valid_i & state==NORMAL & !flush_i & full & !pop sets overflow_o on the next edge. It stays set until reset. The response is dropped.
- stall_req_o:
  - Registered: next value = (next_count >= DEPTH-1) & !flush_i.
  - The threshold leaves one slot for the response already in flight when the stall takes effect.
  - Deasserts the cycle after occupancy drops below DEPTH-1.
- Latency: a response accepted at edge N appears on id_* after edge N (zero-cycle bypass is not provided).

Test Plan:
- Reset, then 3 responses pc=0x80000000/04/08, id_ready_i=1 throughout -> id_valid_o rises the cycle after each push; id_pc_o sequence 0x80000000, 0x80000004, 0x80000008; count_o never exceeds 1.
- id_ready_i=0 with continuous responses -> count_o 1,2,3. stall_req_o=1 after count reaches 3. The 4th in-flight response is accepted (count=4, overflow_o=0). A forced 5th response sets overflow_o=1, and overflow_o remains 1.
- Full queue, id_ready_i=1 with a simultaneous response -> count stays 4, order preserved, no overflow.
- Queue holding 2 entries; flush_i with a response in the same cycle -> next cycle count_o=0, id_valid_o=0, FSM=DROP. Next response (stale pc=0x8000000c) is discarded. Following response pc=0x80001000 is enqueued and presented.
- Back-to-back flush_i on two cycles with a response between -> the response is discarded, FSM remains DROP, and only the first post-second-flush response is dropped.
- Assert rst asynchronously mid-stream with 3 entries -> outputs go to 0 immediately, without waiting for clk. After release, the queue operates from empty.
